// File: rtl/secure_data_pipe.sv
// Masking buffer pipeline: words are XORed with a key on entry, flushable (zeroize) on request.
// Optional feature macro: SECURE_DATA_PIPE_OUT_SCRUB_EN forces out_data to zero whenever out_valid is low.
module secure_data_pipe #(
    parameter int                DATA_W  = 128,
    parameter int                STAGES  = 3,
    parameter logic [DATA_W-1:0] KEY_RST = {DATA_W/8{8'hA5}}
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         key_load,
    input  logic [DATA_W-1:0]            key_in,
    input  logic                         flush_req,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(STAGES+1)-1:0]  occupancy,
    output logic                         flush_done,
    output logic                         busy
);

    localparam int OCC_W = $clog2(STAGES + 1);
    localparam int CNT_W = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int LAST  = STAGES - 1;

    // state | meaning
    // IDLE  | all stages empty
    // RUN   | at least one stage holds a word
    // FLUSH | zeroizing stage[cnt] each cycle, key cleared on the last one
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q [STAGES];
    logic [DATA_W-1:0]   data_d [STAGES];
    logic [DATA_W-1:0]   src    [STAGES];
    logic [STAGES-1:0]   valid_q, valid_d, adv, fill;
    logic [DATA_W-1:0]   key_q, key_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [OCC_W-1:0]    occ_q, occ_d;
    logic                flush_done_q, flush_done_d;
    logic                out_valid_int, in_ready_int, in_fire;

    assign out_valid_int = rst_n & valid_q[LAST] & (state_q != FLUSH);
    assign in_ready_int  = rst_n & (state_q != FLUSH) & ~flush_req & (~valid_q[0] | adv[0]);
    assign in_fire       = in_valid & in_ready_int;

    // Advance chain resolved from the output end backwards through a scalar carry.
    always_comb begin
        logic nxt;
        adv       = '0;
        nxt       = out_valid_int & out_ready;
        adv[LAST] = nxt;
        for (int i = LAST - 1; i >= 0; i--) begin
            nxt    = valid_q[i] & (~valid_q[i+1] | nxt);
            adv[i] = nxt;
        end
    end

    always_comb begin
        fill[0] = in_fire;
        src[0]  = in_data ^ key_q;
        for (int i = 1; i < STAGES; i++) begin
            fill[i] = adv[i-1];
            src[i]  = data_q[i-1];
        end
    end

    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        cnt_d        = cnt_q;
        flush_done_d = 1'b0;
        data_d       = data_q;
        valid_d      = valid_q;
        occ_d        = '0;
        if (state_q == FLUSH) begin
            for (int i = 0; i < STAGES; i++) begin
                if (i == int'(cnt_q)) begin
                    data_d[i]  = '0;
                    valid_d[i] = 1'b0;
                end
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(LAST)) begin
                key_d        = '0;
                cnt_d        = '0;
                flush_done_d = 1'b1;
                state_d      = IDLE;
            end
        end else begin
            // A departing word with no replacement leaves a zeroed slot behind.
            for (int i = 0; i < STAGES; i++) begin
                if (fill[i]) begin
                    data_d[i]  = src[i];
                    valid_d[i] = 1'b1;
                end else if (adv[i]) begin
                    data_d[i]  = '0;
                    valid_d[i] = 1'b0;
                end
            end
            if (key_load) begin
                key_d = key_in;
            end
        end
        for (int i = 0; i < STAGES; i++) begin
            occ_d = occ_d + OCC_W'(valid_d[i]);
        end
        if (state_q != FLUSH) begin
            cnt_d = '0;
            if (flush_req) begin
                state_d = FLUSH;
            end else if (occ_d != '0) begin
                state_d = RUN;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
            valid_q      <= '0;
            key_q        <= KEY_RST;
            cnt_q        <= '0;
            occ_q        <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            key_q        <= key_d;
            cnt_q        <= cnt_d;
            occ_q        <= occ_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign in_ready   = in_ready_int;
    assign out_valid  = out_valid_int;
    assign occupancy  = occ_q;
    assign flush_done = flush_done_q;
    assign busy       = (state_q != IDLE) | (occ_q != '0);

`ifdef SECURE_DATA_PIPE_OUT_SCRUB_EN
    assign out_data = out_valid_int ? data_q[LAST] : '0;
`else
    assign out_data = data_q[LAST];
`endif

endmodule

// File: tb/tb_secure_data_pipe.sv
// Self-checking bench for secure_data_pipe: vector table plus flush/reset sequences, scoreboard on outputs.
module tb_secure_data_pipe;

    localparam int DW = 128;
    localparam int ST = 3;
    localparam logic [DW-1:0] A5   = {16{8'hA5}};
    localparam logic [DW-1:0] ONES = {DW{1'b1}};

    logic          clk = 1'b0;
    logic          rst_n, in_valid, in_ready, key_load, flush_req;
    logic          out_valid, out_ready, flush_done, busy;
    logic [DW-1:0] in_data, key_in, out_data;
    logic [1:0]    occupancy;

    always #5 clk = ~clk;

    secure_data_pipe #(.DATA_W(DW), .STAGES(ST)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .key_load   (key_load),
        .key_in     (key_in),
        .flush_req  (flush_req),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .occupancy  (occupancy),
        .flush_done (flush_done),
        .busy       (busy)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          kl;
        logic [DW-1:0] key;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t          tab [7];
    logic [DW-1:0] sb [$];
    int            tests = 0;
    int            fails = 0;
    logic          mon_en = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: got %h expected no word", out_data);
            end else begin
                check("sb_out", out_data, sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] e,
                        input logic kl, input logic [DW-1:0] k);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        key_load = kl;
        key_in   = k;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                done = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
        key_load = 1'b0;
        key_in   = '0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got no in_ready expected in_ready within 50 cycles");
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (occupancy == 0 && !out_valid) done = 1'b1;
            tick();
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got occupancy %0d expected 0", occupancy);
        end
    endtask

    task automatic set_key(input logic [DW-1:0] k);
        key_load = 1'b1;
        key_in   = k;
        tick();
        key_load = 1'b0;
        key_in   = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tab[0] = '{data: '0,            kl: 1'b0, key: '0,            exp: A5};
        tab[1] = '{data: ONES,          kl: 1'b1, key: ONES,          exp: ~A5};
        tab[2] = '{data: '0,            kl: 1'b0, key: '0,            exp: ONES};
        tab[3] = '{data: 128'h1234,     kl: 1'b1, key: '0,            exp: ~128'h1234};
        tab[4] = '{data: 128'h1234,     kl: 1'b0, key: '0,            exp: 128'h1234};
        tab[5] = '{data: A5,            kl: 1'b1, key: 128'h0F0F,     exp: A5};
        tab[6] = '{data: '0,            kl: 1'b0, key: '0,            exp: 128'h0F0F};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; key_load = 1'b0; key_in = '0;
        flush_req = 1'b0; out_ready = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_flush_done", flush_done, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        tick();
        mon_en = 1'b1;

        // first word latency with the reset key
        out_ready = 1'b1;
        send('0, A5, 1'b0, '0);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
        end
        check("latency", n, ST);
        tick();
        drain();

        for (int i = 0; i < 7; i++) begin
            send(tab[i].data, tab[i].exp, tab[i].kl, tab[i].key);
        end
        drain();
        @(negedge clk);
        check("empty_out_data", out_data, 0);
        tick();

        // backpressure: three words fill, fourth stalls
        set_key('0);
        out_ready = 1'b0;
        for (int w = 1; w <= 3; w++) send(DW'(w), DW'(w), 1'b0, '0);
        in_valid = 1'b1;
        in_data  = DW'(4);
        @(negedge clk);
        check("full_in_ready", in_ready, 0);
        check("full_occupancy", occupancy, 3);
        check("full_out_valid", out_valid, 1);
        check("full_out_data", out_data, 1);
        tick();
        @(negedge clk);
        check("hold_out_data", out_data, 1);
        check("hold_in_ready", in_ready, 0);
        tick();
        out_ready = 1'b1;
        send(DW'(4), DW'(4), 1'b0, '0);
        send(DW'(5), DW'(5), 1'b0, '0);
        drain();
        @(negedge clk);
        check("drained_out_data", out_data, 0);
        check("drained_busy", busy, 0);
        tick();

        // flush with two words resident
        out_ready = 1'b0;
        send(DW'(11), DW'(11), 1'b0, '0);
        send(DW'(12), DW'(12), 1'b0, '0);
        @(negedge clk);
        check("pre_flush_occ", occupancy, 2);
        tick();
        flush_req = 1'b1;
        in_valid  = 1'b1;
        in_data   = DW'(99);
        @(negedge clk);
        check("flush_req_in_ready", in_ready, 0);
        tick();
        flush_req = 1'b0;
        in_valid  = 1'b0;
        sb.delete();
        for (int c = 0; c < ST; c++) begin
            key_load  = (c == 1);
            key_in    = (c == 1) ? ONES : '0;
            flush_req = (c == 1);
            @(negedge clk);
            check("flush_in_ready", in_ready, 0);
            check("flush_out_valid", out_valid, 0);
            check("flush_busy", busy, 1);
            check("flush_done_early", flush_done, 0);
            tick();
        end
        key_load = 1'b0; key_in = '0; flush_req = 1'b0;
        @(negedge clk);
        check("flush_done_pulse", flush_done, 1);
        check("flush_occ", occupancy, 0);
        check("flush_busy_end", busy, 0);
        check("flush_out_data", out_data, 0);
        tick();
        @(negedge clk);
        check("flush_done_single", flush_done, 0);
        tick();
        out_ready = 1'b1;
        send(128'h1234, 128'h1234, 1'b0, '0);
        drain();

        // reset in the second flush cycle
        out_ready = 1'b0;
        send(DW'(21), DW'(21), 1'b0, '0);
        send(DW'(22), DW'(22), 1'b0, '0);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        sb.delete();
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_flush_in_ready", in_ready, 0);
        check("rst_flush_out_valid", out_valid, 0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("abort_no_done", flush_done, 0);
            tick();
        end
        @(negedge clk);
        check("abort_occ", occupancy, 0);
        check("abort_busy", busy, 0);
        tick();
        out_ready = 1'b1;
        send('0, A5, 1'b0, '0);
        drain();

        repeat (3) tick();
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/secure_data_pipe.md
SECURE_DATA_PIPE -- requirements
Module: secure_data_pipe

Interface
REQ-001 SHALL provide parameter DATA_W, default 128, datapath width in bits (8..256).
REQ-002 SHALL provide parameter STAGES, default 3, number of buffer stages (1..16).
REQ-003 SHALL provide parameter KEY_RST, default {DATA_W/8{8'hA5}}, key register value after reset.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous reset, active-low (one clock; reset synchronous, active-low).
REQ-006 SHALL have port in_valid  input  1  input word present.
REQ-007 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-008 SHALL have port in_data  input  DATA_W  sensitive plaintext word.
REQ-009 SHALL have port key_load  input  1  load key_in into key register.
REQ-010 SHALL have port key_in  input  DATA_W  new mask key.
REQ-011 SHALL have port flush_req  input  1  single-cycle request to zeroize all storage.
REQ-012 SHALL have port out_valid  output  1  output word present.
REQ-013 SHALL have port out_ready  input  1  consumer accepts output.
REQ-014 SHALL have port out_data  output  DATA_W  masked word.
REQ-015 SHALL have port occupancy  output  $clog2(STAGES+1)  count of valid stages.
REQ-016 SHALL have port flush_done  output  1  one-cycle pulse at flush completion.
REQ-017 SHALL have port busy  output  1  high when state != IDLE or occupancy != 0.

Function
REQ-018 SHALL implement an FSM with states IDLE (empty), RUN (occupancy > 0), FLUSH.
REQ-019 Input transfer SHALL occur when in_valid & in_ready; stage0 then loads in_data XOR key register value before any same-cycle key_load.
REQ-020 in_ready SHALL be high only when state != FLUSH, flush_req low, and stage0 empty or advancing.
REQ-021 Stage i SHALL advance into stage i+1 when stage i+1 is empty or advancing; last stage advances on out_valid & out_ready.
REQ-022 out_valid/out_data SHALL come from the last stage; latency from input transfer to out_valid SHALL be STAGES cycles without backpressure; throughput one word/cycle.
REQ-023 A stage whose word departs with no replacement SHALL be zeroed on that same edge; an invalid stage SHALL always hold all-zero data.
REQ-024 out_valid SHALL stay high with out_data stable until accepted.
REQ-025 key_load SHALL update the key register next edge, except in FLUSH where it is ignored.
REQ-026 flush_req in IDLE or RUN SHALL enter FLUSH next edge; an output transfer in the same cycle completes, an input transfer does not occur.
REQ-027 FLUSH SHALL use a counter 0..STAGES-1, zeroing data and valid of stage[counter] each cycle; out_valid SHALL be low throughout FLUSH.
REQ-028 On the last FLUSH cycle the key register SHALL be zeroed, flush_done pulsed next cycle, and state returned to IDLE.
REQ-029 flush_req during FLUSH SHALL be ignored.
REQ-030 occupancy SHALL equal the number of valid stages, updated each edge.

Reset
REQ-031 On rst_n low at a clock edge: all stages and valids zero, key register = KEY_RST, counter 0, state IDLE.
REQ-032 Outputs in reset: in_ready 0, out_valid 0, out_data 0, occupancy 0, flush_done 0, busy 0.
REQ-033 Reset during FLUSH SHALL abort it without a flush_done pulse.

Configuration
REQ-034 Macro SECURE_DATA_PIPE_OUT_SCRUB_EN: when defined, out_data SHALL read all-zero whenever out_valid is low; when undefined, out_data SHALL equal raw last-stage data (zero when empty per REQ-023, stale nowhere else).

Verification
REQ-035 DATA_W=128, STAGES=3, default key; in_data=0x0 accepted, out_ready=1 -> out_valid after 3 cycles, out_data=0xA5A5...A5.
REQ-036 Stream 5 words back-to-back, out_ready held 0 -> in_ready drops after 3 accepted, occupancy=3; release out_ready -> words exit in order, empty stages read zero.
REQ-037 key_load key_in=0xFF..FF same cycle as accepting 0x0 -> that word exits 0xA5..A5; next word 0x0 exits 0xFF..FF.
REQ-038 Occupancy 2, flush_req -> FLUSH for 3 cycles, in_ready=0, flush_done pulse, all stages and key read zero, state IDLE.
REQ-039 rst_n low during second FLUSH cycle -> no flush_done, key=KEY_RST, occupancy 0.
REQ-040 With SECURE_DATA_PIPE_OUT_SCRUB_EN defined, after final output transfer -> out_data=0 next cycle.
